// File: rtl/cfg_chain_pkg.sv
// Shared types and constants for the configuration-chain loader.
package cfg_chain_pkg;

  localparam int unsigned WORD_W   = 32;
  localparam logic [31:0] CRC_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_VERIFY,
    ST_DONE,
    ST_ERROR
  } state_t;

  typedef logic [WORD_W-1:0] cfg_word_t;

  // One MSB-first CRC-32 step, no reflection, no final XOR.
  function automatic logic [31:0] crc32_step(input logic [31:0] crc, input logic bit_in);
    logic fb;
    fb = crc[31] ^ bit_in;
    return {crc[30:0], 1'b0} ^ (fb ? CRC_POLY : 32'h0);
  endfunction

endpackage

// File: rtl/cfg_chain_loader_if.sv
// Host configuration word stream (valid/ready).
interface cfg_chain_loader_if;
  import cfg_chain_pkg::*;

  cfg_word_t cfg_data;
  logic      cfg_valid;
  logic      cfg_ready;

  modport master (output cfg_data, output cfg_valid, input  cfg_ready);
  modport slave  (input  cfg_data, input  cfg_valid, output cfg_ready);
endinterface

// File: rtl/crc32_serial.sv
// Bit-serial CRC-32 accumulator; clr has priority over en.
module crc32_serial
  import cfg_chain_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [31:0] crc
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC_INIT;
    end else if (clr) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= crc32_step(crc, bit_in);
    end
  end

endmodule

// File: rtl/cfg_chain_loader.sv
// Loads 32-bit words bit-serially into the core program chain, then
// recirculates the chain once and compares CRCs of loaded vs returned bits.
module cfg_chain_loader
  import cfg_chain_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 4096
) (
  input  logic              prog_clk,
  input  logic              rst_n,
  input  logic              start,
  cfg_chain_loader_if.slave cfg,
  output logic              prog_en,
  output logic              prog_in,
  input  logic              prog_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       crc_out
);

  localparam int unsigned WORDS    = CHAIN_LEN / WORD_W;
  localparam int unsigned CNT_W    = $clog2(CHAIN_LEN + 1);
  localparam int unsigned WCNT_W   = $clog2(WORDS + 1);
  localparam int unsigned SR_CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);

  state_t              state_q, state_n;
  cfg_word_t           sr_q, sr_n;
  logic [SR_CNT_W-1:0] sr_cnt_q, sr_cnt_n;
  logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_n;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_n;
  logic                cfg_ready_q, cfg_ready_n;
  logic                prog_en_q, prog_en_n;
  logic                prog_in_q, prog_in_n;
  logic                busy_q, busy_n;
  logic                done_q, done_n;
  logic                error_q, error_n;
  logic [31:0]         crc_out_q, crc_out_n;

  logic                crc_clr, crc_a_en, crc_b_en;
  logic [31:0]         crc_a, crc_b;
  logic                load_n;

  crc32_serial u_crc_a (
    .clk    (prog_clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_a_en),
    .bit_in (sr_q[WORD_W-1]),
    .crc    (crc_a)
  );

  crc32_serial u_crc_b (
    .clk    (prog_clk),
    .rst_n  (rst_n),
    .clr    (crc_clr),
    .en     (crc_b_en),
    .bit_in (prog_out),
    .crc    (crc_b)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n    = state_q;
    sr_n       = sr_q;
    sr_cnt_n   = sr_cnt_q;
    bit_cnt_n  = bit_cnt_q;
    word_cnt_n = word_cnt_q;
    busy_n     = busy_q;
    done_n     = done_q;
    error_n    = error_q;
    crc_out_n  = crc_out_q;
    crc_clr    = 1'b0;
    crc_a_en   = 1'b0;
    crc_b_en   = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_n    = ST_LOAD;
          sr_cnt_n   = '0;
          bit_cnt_n  = '0;
          word_cnt_n = '0;
          crc_clr    = 1'b1;
          busy_n     = 1'b1;
          done_n     = 1'b0;
          error_n    = 1'b0;
        end
      end
      ST_LOAD: begin
        if (sr_cnt_q != '0) begin
          sr_n      = {sr_q[WORD_W-2:0], 1'b0};
          sr_cnt_n  = sr_cnt_q - SR_CNT_W'(1);
          bit_cnt_n = bit_cnt_q + CNT_W'(1);
          crc_a_en  = 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_n   = ST_VERIFY;
            bit_cnt_n = '0;
          end
        end
        // A word accepted while bit 0 shifts reloads with no bubble.
        if (cfg.cfg_valid && cfg_ready_q) begin
          sr_n       = cfg.cfg_data;
          sr_cnt_n   = SR_CNT_W'(WORD_W);
          word_cnt_n = word_cnt_q + WCNT_W'(1);
        end
      end
      ST_VERIFY: begin
        crc_b_en  = 1'b1;
        bit_cnt_n = bit_cnt_q + CNT_W'(1);
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_n = '0;
          busy_n    = 1'b0;
          crc_out_n = crc_a;
          if (crc32_step(crc_b, prog_out) == crc_a) begin
            state_n = ST_DONE;
            done_n  = 1'b1;
          end else begin
            state_n = ST_ERROR;
            error_n = 1'b1;
          end
        end
      end
      default: state_n = ST_IDLE;
    endcase

    load_n      = (state_n == ST_LOAD);
    cfg_ready_n = load_n && (sr_cnt_n <= SR_CNT_W'(1)) && (word_cnt_n < WCNT_W'(WORDS));
    prog_en_n   = (load_n && (sr_cnt_n != '0)) || (state_n == ST_VERIFY);
    prog_in_n   = load_n && (sr_cnt_n != '0) && sr_n[WORD_W-1];
  end

  always_ff @(posedge prog_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sr_q        <= '0;
      sr_cnt_q    <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
      cfg_ready_q <= 1'b0;
      prog_en_q   <= 1'b0;
      prog_in_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      crc_out_q   <= '0;
    end else begin
      state_q     <= state_n;
      sr_q        <= sr_n;
      sr_cnt_q    <= sr_cnt_n;
      bit_cnt_q   <= bit_cnt_n;
      word_cnt_q  <= word_cnt_n;
      cfg_ready_q <= cfg_ready_n;
      prog_en_q   <= prog_en_n;
      prog_in_q   <= prog_in_n;
      busy_q      <= busy_n;
      done_q      <= done_n;
      error_q     <= error_n;
      crc_out_q   <= crc_out_n;
    end
  end

  // Verify recirculates the chain output straight back to its input.
  assign prog_in       = (state_q == ST_VERIFY) ? prog_out : prog_in_q;
  assign prog_en       = prog_en_q;
  assign cfg.cfg_ready = cfg_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign error         = error_q;
  assign crc_out       = crc_out_q;

endmodule
